// File: rtl/apb_master_bridge.sv
// APB requester: turns a valid/ready command stream into single APB transfers
// and returns read data / error / timeout status on a valid/ready response channel.
module apb_master_bridge #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  pclk,
    input  logic                  presetn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [DATA_WIDTH-1:0] pwdata,
    input  logic [DATA_WIDTH-1:0] prdata,
    input  logic                  pready,
    input  logic                  pslverr
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W:0] TO_LIMIT = TIMEOUT_CYCLES[CNT_W:0];

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t                  state, state_nxt;
    logic [CNT_W-1:0]        wait_cnt, wait_cnt_nxt;
    logic [CNT_W:0]          wait_inc;
    logic                    timeout_hit;
    logic [ADDR_WIDTH-1:0]   paddr_nxt;
    logic [DATA_WIDTH-1:0]   pwdata_nxt, rsp_rdata_nxt;
    logic                    psel_nxt, penable_nxt, pwrite_nxt;
    logic                    rsp_valid_nxt, rsp_err_nxt, rsp_timeout_nxt;

    assign cmd_ready   = (state == IDLE);
    assign wait_inc    = {1'b0, wait_cnt} + {{CNT_W{1'b0}}, 1'b1};
    // Abort fires on the edge that would be the TIMEOUT_CYCLES-th low-pready ACCESS edge.
    assign timeout_hit = (TIMEOUT_CYCLES > 0) && (wait_inc == TO_LIMIT);

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            paddr       <= '0;
            pwdata      <= '0;
            pwrite      <= 1'b0;
            psel        <= 1'b0;
            penable     <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            state       <= state_nxt;
            wait_cnt    <= wait_cnt_nxt;
            paddr       <= paddr_nxt;
            pwdata      <= pwdata_nxt;
            pwrite      <= pwrite_nxt;
            psel        <= psel_nxt;
            penable     <= penable_nxt;
            rsp_valid   <= rsp_valid_nxt;
            rsp_rdata   <= rsp_rdata_nxt;
            rsp_err     <= rsp_err_nxt;
            rsp_timeout <= rsp_timeout_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        wait_cnt_nxt    = wait_cnt;
        paddr_nxt       = paddr;
        pwdata_nxt      = pwdata;
        pwrite_nxt      = pwrite;
        psel_nxt        = psel;
        penable_nxt     = penable;
        rsp_valid_nxt   = rsp_valid;
        rsp_rdata_nxt   = rsp_rdata;
        rsp_err_nxt     = rsp_err;
        rsp_timeout_nxt = rsp_timeout;

        case (state)
            IDLE: begin
                psel_nxt    = 1'b0;
                penable_nxt = 1'b0;
                if (cmd_valid) begin
                    paddr_nxt  = cmd_addr;
                    pwdata_nxt = cmd_wdata;
                    pwrite_nxt = cmd_write;
                    psel_nxt   = 1'b1;
                    state_nxt  = SETUP;
                end
            end
            SETUP: begin
                penable_nxt = 1'b1;
                state_nxt   = ACCESS;
            end
            ACCESS: begin
                // A completing slave beats an expiring timeout on the same edge.
                if (pready) begin
                    rsp_rdata_nxt   = pwrite ? '0 : prdata;
                    rsp_err_nxt     = pslverr;
                    rsp_timeout_nxt = 1'b0;
                    psel_nxt        = 1'b0;
                    penable_nxt     = 1'b0;
                    rsp_valid_nxt   = 1'b1;
                    state_nxt       = RESP;
                end else if (timeout_hit) begin
                    rsp_rdata_nxt   = '0;
                    rsp_err_nxt     = 1'b1;
                    rsp_timeout_nxt = 1'b1;
                    psel_nxt        = 1'b0;
                    penable_nxt     = 1'b0;
                    rsp_valid_nxt   = 1'b1;
                    state_nxt       = RESP;
                end else begin
                    wait_cnt_nxt = wait_inc[CNT_W-1:0];
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_nxt = 1'b0;
                    wait_cnt_nxt  = '0;
                    state_nxt     = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge: small APB memory slave, checks sampled on negedge.
module tb_apb_master_bridge;

    logic        pclk = 1'b0;
    logic        presetn = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic [31:0] paddr;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready = 1'b1;
    logic        pslverr = 1'b0;

    int tests = 0;
    int failed = 0;

    logic [31:0] mem [0:63];

    apb_master_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
        .pclk(pclk), .presetn(presetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
        .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    always #5 pclk = ~pclk;

    always @(posedge pclk) begin
        if (psel && penable && pwrite && pready) mem[paddr[7:2]] <= pwdata;
    end
    assign prdata = mem[paddr[7:2]];

    task automatic tick();
        @(posedge pclk);
        @(negedge pclk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic start_cmd(input logic w, input logic [31:0] a, input logic [31:0] d);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        tick();
        cmd_valid = 1'b0;
        chk("setup_psel", {31'd0, psel}, 32'd1);
        chk("setup_penable", {31'd0, penable}, 32'd0);
        chk("setup_paddr", paddr, a);
        chk("setup_pwrite", {31'd0, pwrite}, {31'd0, w});
        chk("setup_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    endtask

    task automatic finish_rsp();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("done_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("done_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        tick();
        tick();
        chk("rst_psel", {31'd0, psel}, 32'd0);
        chk("rst_penable", {31'd0, penable}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_paddr", paddr, 32'd0);
        chk("rst_pwdata", pwdata, 32'd0);
        presetn = 1'b1;
        tick();
        chk("rel_cmd_ready", {31'd0, cmd_ready}, 32'd1);

        // 1: zero-wait write then read back
        start_cmd(1'b1, 32'h10, 32'hDEADBEEF);
        chk("t1_pwdata", pwdata, 32'hDEADBEEF);
        tick();
        chk("t1_access_psel", {31'd0, psel}, 32'd1);
        chk("t1_access_penable", {31'd0, penable}, 32'd1);
        tick();
        chk("t1_done_psel", {31'd0, psel}, 32'd0);
        chk("t1_done_penable", {31'd0, penable}, 32'd0);
        chk("t1_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("t1_rsp_err", {31'd0, rsp_err}, 32'd0);
        chk("t1_rsp_rdata", rsp_rdata, 32'd0);
        chk("t1_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        finish_rsp();
        start_cmd(1'b0, 32'h10, 32'h0);
        tick();
        tick();
        chk("t1_rd_valid", {31'd0, rsp_valid}, 32'd1);
        chk("t1_rd_rdata", rsp_rdata, 32'hDEADBEEF);
        finish_rsp();

        // 2: read with three wait states
        start_cmd(1'b1, 32'h20, 32'h0BADF00D);
        tick();
        tick();
        chk("t2_wr_valid", {31'd0, rsp_valid}, 32'd1);
        finish_rsp();
        pready = 1'b0;
        start_cmd(1'b0, 32'h20, 32'h0);
        tick();
        chk("t2_penable_0", {31'd0, penable}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t2_wait_penable", {31'd0, penable}, 32'd1);
            chk("t2_wait_paddr", paddr, 32'h20);
            chk("t2_wait_pwrite", {31'd0, pwrite}, 32'd0);
            chk("t2_wait_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        end
        pready = 1'b1;
        tick();
        chk("t2_penable_off", {31'd0, penable}, 32'd0);
        chk("t2_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("t2_rsp_rdata", rsp_rdata, 32'h0BADF00D);
        finish_rsp();

        // 3: slave error
        pslverr = 1'b1;
        start_cmd(1'b1, 32'h30, 32'h000055AA);
        tick();
        tick();
        pslverr = 1'b0;
        chk("t3_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("t3_rsp_err", {31'd0, rsp_err}, 32'd1);
        chk("t3_rsp_timeout", {31'd0, rsp_timeout}, 32'd0);
        finish_rsp();

        // 4a: pready stuck low -> timeout after 16 ACCESS edges
        pready = 1'b0;
        start_cmd(1'b0, 32'h40, 32'h0);
        tick();
        for (int i = 0; i < 15; i++) tick();
        chk("t4_psel_before", {31'd0, psel}, 32'd1);
        chk("t4_valid_before", {31'd0, rsp_valid}, 32'd0);
        tick();
        chk("t4_psel", {31'd0, psel}, 32'd0);
        chk("t4_penable", {31'd0, penable}, 32'd0);
        chk("t4_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("t4_rsp_err", {31'd0, rsp_err}, 32'd1);
        chk("t4_rsp_timeout", {31'd0, rsp_timeout}, 32'd1);
        chk("t4_rsp_rdata", rsp_rdata, 32'd0);
        finish_rsp();

        // 4b: pready rises on the 16th edge -> normal completion
        start_cmd(1'b0, 32'h10, 32'h0);
        tick();
        for (int i = 0; i < 15; i++) tick();
        chk("t4b_psel_before", {31'd0, psel}, 32'd1);
        pready = 1'b1;
        tick();
        chk("t4b_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("t4b_rsp_timeout", {31'd0, rsp_timeout}, 32'd0);
        chk("t4b_rsp_err", {31'd0, rsp_err}, 32'd0);
        chk("t4b_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
        finish_rsp();

        // 5: response backpressure with a pending command
        start_cmd(1'b1, 32'h44, 32'h13579BDF);
        tick();
        tick();
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 32'h44;
        cmd_wdata = 32'h0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t5_hold_valid", {31'd0, rsp_valid}, 32'd1);
            chk("t5_hold_cmd_ready", {31'd0, cmd_ready}, 32'd0);
            chk("t5_hold_psel", {31'd0, psel}, 32'd0);
            chk("t5_hold_err", {31'd0, rsp_err}, 32'd0);
            chk("t5_hold_rdata", rsp_rdata, 32'd0);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("t5_rel_valid", {31'd0, rsp_valid}, 32'd0);
        chk("t5_rel_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        tick();
        cmd_valid = 1'b0;
        chk("t5_next_psel", {31'd0, psel}, 32'd1);
        chk("t5_next_paddr", paddr, 32'h44);
        chk("t5_next_pwrite", {31'd0, pwrite}, 32'd0);
        tick();
        tick();
        chk("t5_next_valid", {31'd0, rsp_valid}, 32'd1);
        chk("t5_next_rdata", rsp_rdata, 32'h13579BDF);
        finish_rsp();

        // 6: reset during ACCESS
        pready = 1'b0;
        start_cmd(1'b0, 32'h20, 32'h0);
        tick();
        tick();
        chk("t6_in_access", {31'd0, penable}, 32'd1);
        presetn = 1'b0;
        #1;
        chk("t6_rst_psel", {31'd0, psel}, 32'd0);
        chk("t6_rst_penable", {31'd0, penable}, 32'd0);
        chk("t6_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        tick();
        presetn = 1'b1;
        pready = 1'b1;
        tick();
        chk("t6_rel_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("t6_rel_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        start_cmd(1'b0, 32'h10, 32'h0);
        tick();
        tick();
        chk("t6_rd_valid", {31'd0, rsp_valid}, 32'd1);
        chk("t6_rd_rdata", rsp_rdata, 32'hDEADBEEF);
        finish_rsp();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
APB requester that converts a simple valid/ready command stream into APB SETUP/ACCESS transfers toward memory-mapped APB slaves in the subsystem. It returns each transfer's result on a valid/ready response channel. The block supports slave wait states, slave errors (pslverr) and a programmable ACCESS-phase timeout. It issues one transfer at a time, with no pipelining across transfers.

Parameters:
ADDR_WIDTH, 32, width of cmd_addr/paddr.
DATA_WIDTH, 32, width of data buses.
TIMEOUT_CYCLES, 16, max consecutive ACCESS cycles with pready=0 before abort; 0 disables timeout.

Ports:
pclk  in  1  APB clock; all logic on rising edge.
presetn  in  1  asynchronous active-low reset.
cmd_valid  in  1  command request.
cmd_ready  out  1  bridge can accept a command.
cmd_write  in  1  1=write, 0=read.
cmd_addr  in  ADDR_WIDTH  byte address, passed to paddr unmodified.
cmd_wdata  in  DATA_WIDTH  write data.
rsp_valid  out  1  response available.
rsp_ready  in  1  response consumed.
rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and timeouts.
rsp_err  out  1  pslverr seen or timeout.
rsp_timeout  out  1  transfer aborted by timeout.
paddr  out  ADDR_WIDTH  APB address.
psel  out  1  APB select.
penable  out  1  APB enable.
pwrite  out  1  APB direction.
pwdata  out  DATA_WIDTH  APB write data.
prdata  in  DATA_WIDTH  APB read data.
pready  in  1  APB ready.
pslverr  in  1  APB slave error.

Behaviour:
- Reset: presetn is asynchronous, active-low; clock is pclk.
- Values forced immediately on reset:
  - state=IDLE.
  - psel=0, penable=0, pwrite=0, paddr=0, pwdata=0.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_timeout=0.
  - wait counter=0.
- All APB and rsp outputs are registered. cmd_ready is decoded from state: 1 only in IDLE.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - On the edge where cmd_valid&&cmd_ready: latch cmd_addr/cmd_wdata/cmd_write into paddr/pwdata/pwrite, set psel=1, go to SETUP.
  - Otherwise hold psel=penable=0. paddr/pwdata/pwrite keep their last values.
- SETUP: exactly 1 cycle with psel=1, penable=0. Set penable=1 and go to ACCESS.
- ACCESS: psel=1, penable=1. paddr, pwrite and pwdata are stable for the whole phase.
  - pready=1 at an edge:
    - capture rsp_rdata=prdata for reads, 0 for writes.
    - rsp_err=pslverr, rsp_timeout=0.
    - clear psel/penable, set rsp_valid=1, go to RESP.
  - pready=0: increment wait counter.
  - If TIMEOUT_CYCLES>0 and the counter reaches TIMEOUT_CYCLES (i.e. TIMEOUT_CYCLES consecutive low-pready ACCESS edges):
    - clear psel/penable.
    - rsp_rdata=0, rsp_err=1, rsp_timeout=1, rsp_valid=1.
    - go to RESP.
  - If pready=1 on the same edge the counter would expire, normal completion wins.
- pslverr and prdata are sampled only in ACCESS with pready=1; ignored at all other times.
- RESP:
  - rsp_valid=1; rsp_rdata, rsp_err and rsp_timeout held stable until rsp_valid&&rsp_ready.
  - On that edge: rsp_valid=0, counter=0, go to IDLE.
  - cmd_ready=0 throughout RESP; no new psel asserted.
- Latency, with a zero-wait slave and command accepted at edge E:
  - psel=1 after E.
  - penable=1 after E+1.
  - completion at E+2; rsp_valid=1 after E+2.
  - Minimum 4 cycles per transfer including the IDLE accept cycle.
- Each wait state adds 1 cycle.
- Unaligned addresses are passed through unchanged.
- Reset mid-transfer (any state): all outputs drop asynchronously and the transfer is discarded with no response. After reset release, cmd_ready=1 in the first cycle.

Test Plan:
1. Zero-wait memory slave; write addr 0x10 data 0xDEADBEEF -> psel 1 cycle before penable, penable high 1 cycle, rsp_valid next cycle with rsp_err=0, rsp_rdata=0. Then read 0x10 -> rsp_rdata=0xDEADBEEF.
2. Read 0x20 with pready low for 3 ACCESS cycles -> penable high 4 cycles; paddr/pwrite stable throughout; rsp_valid one cycle after pready.
3. Write 0x30 with slave returning pready=1, pslverr=1 -> rsp_err=1, rsp_timeout=0; bridge returns to IDLE after rsp_ready.
4. TIMEOUT_CYCLES=16, pready stuck 0 -> psel/penable drop after 16 ACCESS edges; rsp_err=1, rsp_timeout=1, rsp_rdata=0. Repeat with pready rising exactly on the 16th edge -> normal completion, rsp_timeout=0.
5. Hold rsp_ready=0 for 5 cycles with cmd_valid=1 -> rsp fields stable, cmd_ready=0, psel=0. After rsp_ready the next command is accepted and completes normally.
6. Assert presetn=0 during ACCESS -> psel, penable and rsp_valid go 0 immediately, no response. After release cmd_ready=1, and a read of 0x10 completes correctly.
